// File: rtl/mem_lsu_if.sv
// Request/response and SRAM-port bundle for mem_lsu; slave is the LSU side,
// master is the execute stage plus data_sram side.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        data_sram_en;
  logic        data_sram_wen;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_sram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_sram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// One-at-a-time load/store unit for a 64-bit SRAM without byte enables; partial stores do read-modify-write.
// Response 2 cycles after accept (load, dword store), 3 (partial store), 1 (trapped misalign, LSU_MISALIGN_TRAP_EN); ready only in IDLE, no resp backpressure.
module mem_lsu #(
  parameter int IDX_W = 7
) (
  input  logic     clk,
  input  logic     reset,
  mem_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_we;
  logic             r_unsigned;
  logic             r_err;
  logic [1:0]       r_size;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_off;
  logic [63:0]      r_wdata;
  logic [63:0]      r_old;
  logic [63:0]      r_rdata;

  logic        w_trap;
  logic [2:0]  w_off;
  logic [5:0]  w_shamt;
  logic [63:0] w_idx64;
  logic [63:0] w_byte_mask;
  logic [63:0] w_shifted;
  logic [63:0] w_ext;
  logic [63:0] w_merge;
  logic        w_sx;
  logic        w_unused_addr;

  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  assign w_unused_addr = ^bus.req_addr[63:IDX_W+3];

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (bus.req_addr[2:0] & size_mask(bus.req_size)) != 3'd0;
  assign w_trap     = w_misalign;
`else
  assign w_trap     = 1'b0;
`endif

  // Clearing the low offset bits aligns the access; trapped requests never reach RD/WR.
  assign w_off     = r_off & ~size_mask(r_size);
  assign w_shamt   = {w_off, 3'b000};
  assign w_idx64   = {{(64-IDX_W){1'b0}}, r_idx};
  assign w_shifted = bus.data_sram_rdata >> w_shamt;
  assign w_sx      = !r_unsigned;

  always_comb begin
    w_byte_mask = '1;
    w_ext       = w_shifted;
    case (r_size)
      2'd0: begin
        w_byte_mask = 64'h0000_0000_0000_00FF;
        w_ext       = {{56{w_sx & w_shifted[7]}}, w_shifted[7:0]};
      end
      2'd1: begin
        w_byte_mask = 64'h0000_0000_0000_FFFF;
        w_ext       = {{48{w_sx & w_shifted[15]}}, w_shifted[15:0]};
      end
      2'd2: begin
        w_byte_mask = 64'h0000_0000_FFFF_FFFF;
        w_ext       = {{32{w_sx & w_shifted[31]}}, w_shifted[31:0]};
      end
      default: ;
    endcase
  end

  assign w_merge = (r_size == 2'd3) ? r_wdata
                 : ((r_old & ~(w_byte_mask << w_shamt)) | ((r_wdata & w_byte_mask) << w_shamt));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_trap)                                    w_next = RESP;
          else if (bus.req_we && bus.req_size == 2'd3)   w_next = WR;
          else                                           w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready       = (r_state == IDLE);
    bus.resp_valid      = (r_state == RESP);
    bus.resp_err        = r_err;
    bus.resp_rdata      = (r_we || r_err) ? 64'd0 : r_rdata;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 1'b0;
    bus.data_sram_addr  = 64'd0;
    bus.data_sram_wdata = 64'd0;
    case (r_state)
      RD: begin
        bus.data_sram_en   = 1'b1;
        bus.data_sram_addr = w_idx64;
      end
      WR: begin
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = !reset;
        bus.data_sram_addr  = w_idx64;
        bus.data_sram_wdata = w_merge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'd0;
      r_idx      <= '0;
      r_off      <= 3'd0;
      r_wdata    <= 64'd0;
      r_old      <= 64'd0;
      r_rdata    <= 64'd0;
    end else begin
      if (bus.req_valid && r_state == IDLE) begin
        r_we       <= bus.req_we;
        r_unsigned <= bus.req_unsigned;
        r_err      <= w_trap;
        r_size     <= bus.req_size;
        r_idx      <= bus.req_addr[IDX_W+2:3];
        r_off      <= bus.req_addr[2:0];
        r_wdata    <= bus.req_wdata;
      end
      if (r_state == RD) begin
        r_old <= bus.data_sram_rdata;
        if (!r_we) r_rdata <= w_ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-level reference memory model, SRAM model, and a negedge monitor.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_if bus();
  mem_lsu #(.IDX_W(7)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [63:0] sram    [128];
  logic [63:0] ref_mem [128];

  assign bus.data_sram_rdata = sram[bus.data_sram_addr[6:0]];
  always @(posedge clk)
    if (bus.data_sram_en && bus.data_sram_wen) sram[bus.data_sram_addr[6:0]] <= bus.data_sram_wdata;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          en_cyc;
    logic [6:0]  idx;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = -1;
  int          en_cnt = 0;
  int          resp_cnt = 0;
  logic [63:0] last_rdata = 64'd0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: byte-granular memory, results derived from size/offset rules directly.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata, output exp_t e);
    int n;
    int off;
    int idx;
    n   = 1 << size;
    off = int'(addr[2:0]);
    idx = int'(addr[9:3]);
    e.idx = addr[9:3]; e.rdata = 64'd0; e.err = 1'b0; e.lat = 0; e.en_cyc = 0;
    if (off % n != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      e.err = 1'b1; e.lat = 1; e.en_cyc = 0;
      return;
`else
      off = off - (off % n);
`endif
    end
    if (!we) begin
      for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
      if (!uns && n < 8 && e.rdata[8*n-1])
        for (int i = n; i < 8; i++) e.rdata[8*i +: 8] = 8'hFF;
      e.lat = 2; e.en_cyc = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
      e.lat    = (n == 8) ? 2 : 3;
      e.en_cyc = (n == 8) ? 1 : 2;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      acc_cyc = -1;
      en_cnt  = 0;
    end else begin
      if (bus.data_sram_en) begin
        en_cnt++;
        if (q.size() > 0) chk("sram_idx", bus.data_sram_addr, {57'd0, q[0].idx});
      end else begin
        chk("sram_idle", {bus.data_sram_wen, 63'd0} | bus.data_sram_addr | bus.data_sram_wdata, 64'd0);
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
          chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          chk("sram_cycles", 64'(en_cnt), 64'(e.en_cyc));
        end
        en_cnt = 0;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc;
        en_cnt  = 0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
    exp_t e;
    int   n;
    int   start;
    model(we, size, uns, addr, wdata, e);
    q.push_back(e);
    start            = resp_cnt;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // Garbage with valid held high while busy must be ignored.
    bus.req_valid    = 1'($urandom_range(0, 1));
    bus.req_we       = 1'($urandom_range(0, 1));
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_addr     = {$urandom, $urandom};
    bus.req_wdata    = {$urandom, $urandom};
    n = 0;
    while (resp_cnt == start && n < 10) begin @(posedge clk); #1; n++; end
    bus.req_valid = 1'b0;
    if (resp_cnt == start) begin
      chk("resp_timeout", 64'd1, 64'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [63:0] saved;
    int          start;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'd0; bus.req_wdata = 64'd0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_en", {63'd0, bus.data_sram_en}, 64'd0);
    chk("rst_wen", {63'd0, bus.data_sram_wen}, 64'd0);
    chk("rst_addr", bus.data_sram_addr, 64'd0);
    chk("rst_wdata", bus.data_sram_wdata, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 128; i++) do_req(1'b1, 2'd3, 1'b0, 64'(i) << 3, {$urandom, $urandom});

    do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788);
    do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'd0);
    chk("dword_load", last_rdata, 64'h1122334455667788);

    do_req(1'b1, 2'd3, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    do_req(1'b1, 2'd0, 1'b0, 64'h3, 64'h5A);
    chk("byte_merge", sram[0], 64'hFFFFFFFF5AFFFFFF);

    do_req(1'b1, 2'd3, 1'b0, 64'h8, 64'h0000000080000000);
    do_req(1'b0, 2'd2, 1'b0, 64'h8, 64'd0);
    chk("word_signed", last_rdata, 64'hFFFFFFFF80000000);
    do_req(1'b0, 2'd2, 1'b1, 64'h8, 64'd0);
    chk("word_unsigned", last_rdata, 64'h0000000080000000);

    do_req(1'b1, 2'd3, 1'b0, 64'h0, 64'h0102030405060708);
    do_req(1'b0, 2'd1, 1'b0, 64'h5, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign_err", {63'd0, last_err}, 64'd1);
    chk("misalign_rdata", last_rdata, 64'd0);
`else
    chk("misalign_err", {63'd0, last_err}, 64'd0);
    chk("misalign_rdata", last_rdata, 64'h0000000000000304);
`endif

    // Reset landing on the WR cycle of a byte store must abort it.
    saved = ref_mem[2];
    start = resp_cnt;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h11; bus.req_wdata = 64'hAB;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wen", {63'd0, bus.data_sram_wen}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("abort_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_resp_cnt", 64'(resp_cnt), 64'(start));
    chk("abort_mem", sram[2], saved);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      a      = {$urandom, $urandom};
      a[9:3] = 7'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 128; i++) chk($sformatf("mem[%0d]", i), sram[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
